// File: rtl/i2c_gpio_pkg.sv
// Shared types and constants for the I2C GPIO expander target.
// Register indices match the PCA9554 register map.
package i2c_gpio_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    localparam logic [1:0] REG_INPUT    = 2'd0;
    localparam logic [1:0] REG_OUTPUT   = 2'd1;
    localparam logic [1:0] REG_POLARITY = 2'd2;
    localparam logic [1:0] REG_CONFIG   = 2'd3;

    localparam logic [7:0] OUTPUT_RST   = 8'hFF;
    localparam logic [7:0] POLARITY_RST = 8'h00;
    localparam logic [7:0] CONFIG_RST   = 8'hFF;

endpackage

// File: rtl/i2c_gpio_if.sv
// Open-drain I2C bus bundle: master drives SCL and SDA, target pulls SDA.
// The resolved SDA level is the wired-AND of both drivers.
interface i2c_gpio_if;

    logic scl;
    logic master_sda;
    logic target_sda_oe;
    wire  sda;

    assign sda = master_sda & ~target_sda_oe;

    modport master (output scl, output master_sda, input sda);
    modport slave  (input scl, input sda, output target_sda_oe);

endinterface

// File: rtl/i2c_line_filter.sv
// Synchronizer plus hold filter for one I2C line, with edge strobes.
// Strobes are aligned with the cycle the filtered level first changes.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_LEN-1:0]  hist_q, hist_d;
    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_pin};
        hist_d  = (hist_q << 1) | FILTER_LEN'(sync_q[SYNC_STAGES-1]);
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/i2c_gpio_target.sv
// I2C target exposing a PCA9554-style 8-bit GPIO expander.
// Bits sampled on SCL rise; SDA drive updated only after SCL fall.
module i2c_gpio_target
    import i2c_gpio_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h20,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [7:0] i_gpio_in,
    output logic [7:0] o_gpio_out,
    output logic [7:0] o_gpio_oe,
    output logic       o_busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_scl),
        .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_sda),
        .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] tx_q, tx_d;
    logic [1:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q;
    logic [7:0] out_q, out_d;
    logic [7:0] pol_q, pol_d;
    logic [7:0] cfg_q, cfg_d;
    logic [7:0] gpio_oe_q;
    logic [7:0] gpio_s1_q, gpio_s2_q;

    logic       start, stop;
    logic [7:0] byte_in;
    logic [1:0] rd_ptr;
    logic [7:0] rd_data;

    // A simultaneous SCL edge makes an SDA change a data bit, not a condition.
    assign start   = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop    = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
    assign byte_in = {sh_q[6:0], sda_lvl};

    always_comb begin
        rd_ptr = (state_q == RDATA_ACK) ? ptr_q + 2'd1 : ptr_q;
        unique case (rd_ptr)
            REG_INPUT:    rd_data = gpio_s2_q ^ pol_q;
            REG_OUTPUT:   rd_data = out_q;
            REG_POLARITY: rd_data = pol_q;
            default:      rd_data = cfg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        rw_d     = rw_q;
        phase_d  = phase_q;
        sda_oe_d = sda_oe_q;
        out_d    = out_q;
        pol_d    = pol_q;
        cfg_d    = cfg_q;
        unique case (1'b1)
            start: begin
                state_d  = ADDR;
                bit_d    = 3'd0;
                sda_oe_d = 1'b0;
            end
            stop: begin
                state_d  = IDLE;
                sda_oe_d = 1'b0;
            end
            scl_rise: begin
                unique case (state_q)
                    ADDR, PTR, WDATA: begin
                        sh_d  = byte_in;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            phase_d = 1'b0;
                            unique case (state_q)
                                ADDR: begin
                                    rw_d    = byte_in[0];
                                    state_d = (byte_in[7:1] == I2C_ADDR)
                                            ? ADDR_ACK : IGNORE;
                                end
                                PTR: begin
                                    ptr_d   = byte_in[1:0];
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    unique case (ptr_q)
                                        REG_OUTPUT:   out_d = byte_in;
                                        REG_POLARITY: pol_d = byte_in;
                                        REG_CONFIG:   cfg_d = byte_in;
                                        default:      ;
                                    endcase
                                    ptr_d   = ptr_q + 2'd1;
                                    state_d = WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: phase_d = 1'b1;
                    RDATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = RDATA_ACK;
                        end
                    end
                    RDATA_ACK: begin
                        if (sda_lvl) begin
                            state_d = IGNORE;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            scl_fall: begin
                unique case (state_q)
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        sda_oe_d = ~phase_q;
                        if (phase_q) begin
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d  = RDATA;
                                tx_d     = rd_data;
                                sda_oe_d = ~rd_data[7];
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        tx_d     = tx_q << 1;
                        sda_oe_d = ~tx_q[6];
                    end
                    RDATA_ACK: begin
                        sda_oe_d = 1'b0;
                        if (phase_q) begin
                            ptr_d    = ptr_q + 2'd1;
                            tx_d     = rd_data;
                            sda_oe_d = ~rd_data[7];
                            state_d  = RDATA;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            bit_q     <= 3'd0;
            sh_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= 2'd0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            out_q     <= OUTPUT_RST;
            pol_q     <= POLARITY_RST;
            cfg_q     <= CONFIG_RST;
            gpio_oe_q <= ~CONFIG_RST;
            gpio_s1_q <= 8'h00;
            gpio_s2_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= (state_d != IDLE);
            out_q     <= out_d;
            pol_q     <= pol_d;
            cfg_q     <= cfg_d;
            gpio_oe_q <= ~cfg_d;
            gpio_s1_q <= i_gpio_in;
            gpio_s2_q <= gpio_s1_q;
        end
    end

    assign o_sda_oe   = sda_oe_q;
    assign o_busy     = busy_q;
    assign o_gpio_out = out_q;
    assign o_gpio_oe  = gpio_oe_q;

endmodule

// File: tb/tb_i2c_gpio_target.sv
// Directed bench: an I2C master model drives the expander target.
// Expected values are hand-computed per step.
module tb_i2c_gpio_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       busy;
    int         checks = 0;
    int         failures = 0;
    logic       ack;
    logic [7:0] d;

    i2c_gpio_if bus ();

    always #5 clk = ~clk;

    i2c_gpio_target dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_scl     (bus.scl),
        .i_sda     (bus.sda),
        .o_sda_oe  (bus.target_sda_oe),
        .i_gpio_in (gpio_in),
        .o_gpio_out(gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_busy    (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        bus.master_sda = 1'b1; tick(Q);
        bus.scl = 1'b1;        tick(Q);
        bus.master_sda = 1'b0; tick(Q);
        bus.scl = 1'b0;        tick(Q);
    endtask

    task automatic i2c_stop;
        bus.master_sda = 1'b0; tick(Q);
        bus.scl = 1'b1;        tick(Q);
        bus.master_sda = 1'b1; tick(Q);
        tick(4);
    endtask

    task automatic wbit(input logic b);
        bus.master_sda = b; tick(Q);
        bus.scl = 1'b1;     tick(2 * Q);
        bus.scl = 1'b0;     tick(Q);
    endtask

    task automatic rbit(output logic b);
        bus.master_sda = 1'b1; tick(Q);
        bus.scl = 1'b1;        tick(Q);
        b = bus.sda;           tick(Q);
        bus.scl = 1'b0;        tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic a);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(b);
        a = ~b;
    endtask

    task automatic rbyte(input logic a, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        wbit(~a);
    endtask

    initial begin
        bus.scl = 1'b1;
        bus.master_sda = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(5);
        chk("rst_gpio_out", gpio_out, 8'hFF);
        chk("rst_gpio_oe", gpio_oe, 8'h00);
        chk("rst_sda_oe", bus.target_sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Read CONFIG after reset
        i2c_start;
        wbyte(8'h40, ack); chk("r3_addr_ack", ack, 1'b1);
        wbyte(8'h03, ack); chk("r3_ptr_ack", ack, 1'b1);
        i2c_start;
        wbyte(8'h41, ack); chk("r3_raddr_ack", ack, 1'b1);
        chk("r3_busy", busy, 1'b1);
        rbyte(1'b0, d);    chk("r3_cfg_rst", d, 8'hFF);
        i2c_stop;

        // CONFIG = 0 -> all outputs
        i2c_start;
        wbyte(8'h40, ack); chk("w3_addr_ack", ack, 1'b1);
        wbyte(8'h03, ack); chk("w3_ptr_ack", ack, 1'b1);
        wbyte(8'h00, ack); chk("w3_data_ack", ack, 1'b1);
        i2c_stop;
        chk("w3_gpio_oe", gpio_oe, 8'hFF);
        chk("w3_busy_idle", busy, 1'b0);

        // Auto-increment OUTPUT then POLARITY
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h01, ack);
        wbyte(8'hA5, ack); chk("w1_a5_ack", ack, 1'b1);
        wbyte(8'h3C, ack); chk("w2_3c_ack", ack, 1'b1);
        i2c_stop;
        chk("w1_gpio_out", gpio_out, 8'hA5);
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h02, ack);
        i2c_start;
        wbyte(8'h41, ack);
        rbyte(1'b0, d);    chk("r2_pol", d, 8'h3C);
        i2c_stop;

        // Inverted INPUT via POLARITY, read with auto-increment
        gpio_in = 8'h0F;
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h02, ack);
        wbyte(8'hFF, ack);
        i2c_stop;
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h00, ack);
        i2c_start;
        wbyte(8'h41, ack); chk("rin_addr_ack", ack, 1'b1);
        rbyte(1'b1, d);    chk("rin_input", d, 8'hF0);
        rbyte(1'b0, d);    chk("rin_output", d, 8'hA5);
        i2c_stop;

        // Wrong address is ignored
        i2c_start;
        wbyte(8'h42, ack); chk("bad_addr_nack", ack, 1'b0);
        chk("bad_sda_oe", bus.target_sda_oe, 1'b0);
        wbyte(8'h00, ack); chk("bad_ignore_nack", ack, 1'b0);
        chk("bad_busy", busy, 1'b1);
        i2c_stop;
        chk("bad_busy_idle", busy, 1'b0);
        chk("bad_gpio_out", gpio_out, 8'hA5);
        chk("bad_gpio_oe", gpio_oe, 8'hFF);

        // Read from ptr 3 wraps to INPUT
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h03, ack);
        i2c_start;
        wbyte(8'h41, ack);
        rbyte(1'b1, d);    chk("wrap_cfg", d, 8'h00);
        rbyte(1'b0, d);    chk("wrap_input", d, 8'hF0);
        i2c_stop;

        // STOP mid-byte discards partial data
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h01, ack);
        for (int i = 0; i < 4; i++) wbit(1'b0);
        i2c_stop;
        chk("partial_gpio_out", gpio_out, 8'hA5);

        // Write to INPUT is acked and dropped, ptr still advances
        i2c_start;
        wbyte(8'h40, ack);
        wbyte(8'h00, ack);
        wbyte(8'h55, ack); chk("win_ack", ack, 1'b1);
        chk("win_gpio_out", gpio_out, 8'hA5);
        wbyte(8'h5A, ack);
        i2c_stop;
        chk("win_next_out", gpio_out, 8'h5A);

        // Async reset during address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) wbit(i == 6);
        bus.master_sda = 1'b1; tick(Q);
        bus.scl = 1'b1;        tick(2);
        chk("ack_drive", bus.target_sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ack_async_rel", bus.target_sda_oe, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_out", gpio_out, 8'hFF);
        chk("post_rst_oe", gpio_oe, 8'h00);
        chk("post_rst_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
